// File: rtl/placement_collision_checker_pkg.sv
// Shared constants and types for the setup-phase placement collision checker.
package placement_collision_checker_pkg;

    localparam int X_bits         = 8;
    localparam int Y_bits         = 7;
    localparam int PIXELS_X       = 160;
    localparam int PIXELS_Y       = 120;
    localparam int NEST_num       = 4;
    localparam int SUGARPATCH_num = 8;
    localparam int ENTRIES        = 16;
    localparam int ENTRY_bits     = 4;
    localparam int MIN_SEP        = 4;

    typedef enum logic {
        NEST  = 1'b0,
        PATCH = 1'b1
    } place_type_e;

    typedef struct packed {
        logic [X_bits-1:0] x;
        logic [Y_bits-1:0] y;
        place_type_e       ptype;
    } placement_t;

endpackage

// File: rtl/placement_collision_checker_proximity_cmp.sv
// Compares one stored placement against the query point using a Chebyshev
// box of radius MIN_SEP. Purely combinational; no coordinate wrap.
module placement_proximity_cmp
    import placement_collision_checker_pkg::*;
(
    input  logic              entry_valid,
    input  placement_t        entry,
    input  logic [X_bits-1:0] query_x,
    input  logic [Y_bits-1:0] query_y,
    output logic              hit
);

    logic signed [X_bits:0] dx_s;
    logic signed [Y_bits:0] dy_s;
    logic        [X_bits:0] dx_mag_s;
    logic        [Y_bits:0] dy_mag_s;
    logic                   hit_s;

    // Signed differences one bit wider than the coordinates, then magnitudes.
    always_comb begin
        dx_s = $signed({1'b0, query_x}) - $signed({1'b0, entry.x});
        dy_s = $signed({1'b0, query_y}) - $signed({1'b0, entry.y});
        if (dx_s[X_bits]) begin
            dx_mag_s = -dx_s;
        end else begin
            dx_mag_s = dx_s;
        end
        if (dy_s[Y_bits]) begin
            dy_mag_s = -dy_s;
        end else begin
            dy_mag_s = dy_s;
        end
        hit_s = entry_valid
              && (dx_mag_s <= (X_bits+1)'(MIN_SEP))
              && (dy_mag_s <= (Y_bits+1)'(MIN_SEP));
    end

    assign hit = hit_s;

endmodule

// File: rtl/placement_collision_checker.sv
// Records committed nest / sugar-patch placements densely in a small table and
// answers zero-latency collision queries against all of them plus world bounds.
module placement_collision_checker
    import placement_collision_checker_pkg::*;
(
    input  logic                  setup_clk,
    input  logic                  RESET_SIM,
    input  logic                  clear_tbl,
    input  logic [X_bits-1:0]     collide_x,
    input  logic [Y_bits-1:0]     collide_y,
    output logic                  collision,
    input  logic                  commit_valid,
    input  logic [X_bits-1:0]     commit_x,
    input  logic [Y_bits-1:0]     commit_y,
    input  logic                  commit_type,
    input  logic [ENTRY_bits-1:0] rd_idx,
    output logic [X_bits-1:0]     rd_x,
    output logic [Y_bits-1:0]     rd_y,
    output logic                  rd_type,
    output logic                  rd_valid,
    output logic [ENTRY_bits:0]   count,
    output logic                  full,
    output logic                  overflow
);

    placement_t            entry_r [ENTRIES];
    logic [ENTRIES-1:0]    valid_r;
    logic [ENTRY_bits:0]   count_r;
    logic                  overflow_r;
    logic                  full_s;
    logic                  write_s;
    logic [ENTRIES-1:0]    hit_s;
    logic                  collision_s;
    logic [X_bits-1:0]     rd_x_s;
    logic [Y_bits-1:0]     rd_y_s;
    logic                  rd_type_s;
    logic                  rd_valid_s;

    assign full_s  = (count_r == (ENTRY_bits+1)'(ENTRIES));
    // clear_tbl wins over a simultaneous commit, so the commit is simply lost.
    assign write_s = commit_valid && !full_s && !clear_tbl;

    // Fill counter, valid bits and sticky overflow; clear has priority over commit.
    always_ff @(posedge setup_clk or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            count_r    <= '0;
            valid_r    <= '0;
            overflow_r <= 1'b0;
        end else if (clear_tbl) begin
            count_r    <= '0;
            valid_r    <= '0;
            overflow_r <= 1'b0;
        end else if (commit_valid) begin
            if (full_s) begin
                overflow_r <= 1'b1;
            end else begin
                valid_r[count_r[ENTRY_bits-1:0]] <= 1'b1;
                count_r <= count_r + (ENTRY_bits+1)'(1);
            end
        end
    end

    // Placement payload storage; content is meaningless until its valid bit is set.
    always_ff @(posedge setup_clk) begin
        if (write_s) begin
            entry_r[count_r[ENTRY_bits-1:0]] <= '{x: commit_x, y: commit_y,
                                                 ptype: place_type_e'(commit_type)};
        end
    end

    // One proximity comparator per table slot.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
        placement_proximity_cmp u_cmp (
            .entry_valid (valid_r[g]),
            .entry       (entry_r[g]),
            .query_x     (collide_x),
            .query_y     (collide_y),
            .hit         (hit_s[g])
        );
    end

    // Collision = any table hit or the query lies outside the world.
    always_comb begin
        collision_s = (|hit_s)
                    || (collide_x >= X_bits'(PIXELS_X))
                    || (collide_y >= Y_bits'(PIXELS_Y));
    end

    // Debug readback; unoccupied slots read as zero.
    always_comb begin
        rd_valid_s = valid_r[rd_idx];
        if (rd_valid_s) begin
            rd_x_s    = entry_r[rd_idx].x;
            rd_y_s    = entry_r[rd_idx].y;
            rd_type_s = entry_r[rd_idx].ptype;
        end else begin
            rd_x_s    = '0;
            rd_y_s    = '0;
            rd_type_s = 1'b0;
        end
    end

    assign collision = collision_s;
    assign rd_x      = rd_x_s;
    assign rd_y      = rd_y_s;
    assign rd_type   = rd_type_s;
    assign rd_valid  = rd_valid_s;
    assign count     = count_r;
    assign full      = full_s;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_placement_collision_checker.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a separate monitor pops and compares them against the DUT outputs.
module tb_placement_collision_checker;
    import placement_collision_checker_pkg::*;

    localparam int K_COLL  = 0;
    localparam int K_COUNT = 1;
    localparam int K_FULL  = 2;
    localparam int K_OVF   = 3;
    localparam int K_RD    = 4;

    typedef struct {
        int          kind;
        logic [31:0] expv;
        string       name;
    } exp_t;

    logic                  setup_clk = 1'b0;
    logic                  RESET_SIM = 1'b1;
    logic                  clear_tbl = 1'b0;
    logic [X_bits-1:0]     collide_x = '0;
    logic [Y_bits-1:0]     collide_y = '0;
    logic                  collision;
    logic                  commit_valid = 1'b0;
    logic [X_bits-1:0]     commit_x = '0;
    logic [Y_bits-1:0]     commit_y = '0;
    logic                  commit_type = 1'b0;
    logic [ENTRY_bits-1:0] rd_idx = '0;
    logic [X_bits-1:0]     rd_x;
    logic [Y_bits-1:0]     rd_y;
    logic                  rd_type;
    logic                  rd_valid;
    logic [ENTRY_bits:0]   count;
    logic                  full;
    logic                  overflow;

    exp_t sb[$];
    event chk_ev;
    int   n_total = 0;
    int   n_pass  = 0;

    placement_collision_checker dut (
        .setup_clk    (setup_clk),
        .RESET_SIM    (RESET_SIM),
        .clear_tbl    (clear_tbl),
        .collide_x    (collide_x),
        .collide_y    (collide_y),
        .collision    (collision),
        .commit_valid (commit_valid),
        .commit_x     (commit_x),
        .commit_y     (commit_y),
        .commit_type  (commit_type),
        .rd_idx       (rd_idx),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_type      (rd_type),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 setup_clk = ~setup_clk;

    // Monitor: pop expectations and compare against the live outputs.
    always begin
        @(chk_ev);
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_COLL:  act = {31'd0, collision};
                K_COUNT: act = {27'd0, count};
                K_FULL:  act = {31'd0, full};
                K_OVF:   act = {31'd0, overflow};
                K_RD:    act = {15'd0, rd_valid, rd_type, rd_y, rd_x};
                default: act = 32'hFFFF_FFFF;
            endcase
            n_total++;
            if (act === e.expv) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.expv);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.expv = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic fire();
        #1;
        -> chk_ev;
        #1;
    endtask

    task automatic query(input int x, input int y, input logic exp_c, input string nm);
        collide_x = X_bits'(x);
        collide_y = Y_bits'(y);
        expect_v(K_COLL, {31'd0, exp_c}, nm);
        fire();
    endtask

    task automatic status(input int c, input logic f, input logic o, input string nm);
        expect_v(K_COUNT, 32'(c), {nm, "_count"});
        expect_v(K_FULL, {31'd0, f}, {nm, "_full"});
        expect_v(K_OVF, {31'd0, o}, {nm, "_ovf"});
        fire();
    endtask

    task automatic readback(input int idx, input logic [16:0] v, input string nm);
        rd_idx = ENTRY_bits'(idx);
        expect_v(K_RD, {15'd0, v}, nm);
        fire();
    endtask

    task automatic tick();
        @(posedge setup_clk);
        #2;
    endtask

    task automatic commit(input int x, input int y, input logic t);
        commit_x     = X_bits'(x);
        commit_y     = Y_bits'(y);
        commit_type  = t;
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic clear();
        clear_tbl = 1'b1;
        tick();
        clear_tbl = 1'b0;
    endtask

    initial begin
        // Reset and empty-table behaviour
        #12;
        RESET_SIM = 1'b0;
        tick();
        query(0, 0, 1'b0, "empty_origin");
        status(0, 1'b0, 1'b0, "reset");
        readback(0, 17'd0, "rd_empty");
        query(160, 5, 1'b1, "oob_x");
        query(5, 120, 1'b1, "oob_y");
        query(159, 119, 1'b0, "inbounds_corner");

        // Single nest and box edges
        tick();
        commit(50, 40, 1'b0);
        query(54, 44, 1'b1, "box_corner_hi");
        query(55, 40, 1'b0, "box_x_out");
        query(46, 36, 1'b1, "box_corner_lo");
        query(50, 35, 1'b0, "box_y_out");
        readback(0, {1'b1, 1'b0, 7'd40, 8'd50}, "rd_nest");
        readback(1, 17'd0, "rd_unused");
        status(1, 1'b0, 1'b0, "one_entry");

        // Same-cycle commit and query sees the pre-commit table
        clear();
        status(0, 1'b0, 1'b0, "after_clear");
        query(50, 40, 1'b0, "cleared_hit_gone");
        tick();
        commit_x = 8'd10; commit_y = 7'd10; commit_type = 1'b1; commit_valid = 1'b1;
        query(10, 10, 1'b0, "same_cycle_pre");
        status(0, 1'b0, 1'b0, "same_cycle_pre");
        tick();
        commit_valid = 1'b0;
        query(10, 10, 1'b1, "same_cycle_post");
        status(1, 1'b0, 1'b0, "same_cycle_post");

        // Fill to capacity, then overflow
        for (int i = 1; i < 16; i++) begin
            commit(10 + 9 * i, 60, i[0]);
        end
        status(16, 1'b1, 1'b0, "filled");
        readback(15, {1'b1, 1'b1, 7'd60, 8'd145}, "rd_last");
        commit(100, 100, 1'b0);
        status(16, 1'b1, 1'b1, "overflowed");
        query(100, 100, 1'b0, "dropped_entry");
        tick();
        status(16, 1'b1, 1'b1, "ovf_sticky");

        // Edge coordinates, no wrap-around
        clear();
        status(0, 1'b0, 1'b0, "clear_ovf");
        commit(0, 0, 1'b0);
        query(4, 4, 1'b1, "edge_near_origin");
        query(159, 119, 1'b0, "edge_no_wrap");
        commit(159, 119, 1'b1);
        query(155, 115, 1'b1, "edge_far_corner");
        query(154, 119, 1'b0, "edge_far_out");

        // Asynchronous reset mid-fill
        clear();
        for (int i = 0; i < 5; i++) begin
            commit(30 + 10 * i, 20, 1'b0);
        end
        status(5, 1'b0, 1'b0, "midfill");
        query(30, 20, 1'b1, "midfill_hit");
        RESET_SIM = 1'b1;
        status(0, 1'b0, 1'b0, "async_reset");
        query(30, 20, 1'b0, "async_reset_hit");
        readback(0, 17'd0, "async_reset_rd");
        tick();
        RESET_SIM = 1'b0;
        tick();

        // clear_tbl beats a simultaneous commit
        clear_tbl = 1'b1;
        commit_x = 8'd70; commit_y = 7'd70; commit_type = 1'b0; commit_valid = 1'b1;
        tick();
        clear_tbl = 1'b0;
        commit_valid = 1'b0;
        status(0, 1'b0, 1'b0, "clear_vs_commit");
        query(70, 70, 1'b0, "clear_vs_commit_hit");

        tick();
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
